// File: rtl/lifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lifo_pkg
// Description : Shared constants, op encoding and sizing helper for the stack.
// Revision    : 1.0 - initial release
// ============================================================================
package lifo_pkg;

    localparam int LIFO_DEF_WIDTH = 8;
    localparam int LIFO_DEF_DEPTH = 8;

    // Per-cycle operation after priority resolution (clear > push&pop > push > pop)
    localparam logic [2:0] OP_IDLE = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_REPL = 3'd3;
    localparam logic [2:0] OP_BYP  = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : lifo_stack_if
// Description : Producer/consumer bundle between the stack and its clients.
// Revision    : 1.0 - initial release
// ============================================================================
interface lifo_stack_if
    import lifo_pkg::*;
#(
    parameter int WIDTH = LIFO_DEF_WIDTH,
    parameter int DEPTH = LIFO_DEF_DEPTH
);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [WIDTH-1:0] top;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, push, pop, din,
        input  dout, dout_valid, top, count, empty, full,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, din,
        output dout, dout_valid, top, count, empty, full,
               almost_full, almost_empty, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/lifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : lifo_mem
// Description : DEPTH x WIDTH register array, sync write, registered read,
//               asynchronous peek. Array contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_mem
    import lifo_pkg::*;
#(
    parameter int WIDTH = LIFO_DEF_WIDTH,
    parameter int DEPTH = LIFO_DEF_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [WIDTH-1:0]  wdata,
    input  wire logic              re,
    input  wire logic [ADDR_W-1:0] raddr,
    output      logic [WIDTH-1:0]  rdata,
    input  wire logic [ADDR_W-1:0] paddr,
    output      logic [WIDTH-1:0]  pdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read samples the pre-edge array, so a same-address write is not seen
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign pdata = mem_q[paddr];

endmodule
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// ============================================================================
// Module      : lifo_stack
// Description : Parametrised LIFO with replace-top, empty bypass, peek,
//               occupancy flags, synchronous clear and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int WIDTH     = LIFO_DEF_WIDTH,
    parameter int DEPTH     = LIFO_DEF_DEPTH,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input wire logic    clk,
    input wire logic    rstn,
    lifo_stack_if.slave bus
);

    localparam int CNT_W    = clog2(DEPTH + 1);
    localparam int c_ADDR_W = clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0]    count_q, count_d;
    logic                dout_valid_q, dout_valid_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                byp_sel_q, byp_sel_d;
    logic [WIDTH-1:0]    byp_data_q, byp_data_d;

    logic [2:0]          w_op;
    logic                w_empty;
    logic                w_full;
    logic [c_ADDR_W-1:0] w_top_addr;
    logic [c_ADDR_W-1:0] w_push_addr;
    logic [c_ADDR_W-1:0] w_waddr;
    logic                w_we;
    logic                w_re;
    logic [WIDTH-1:0]    w_rdata;
    logic [WIDTH-1:0]    w_pdata;

    assign w_empty     = (count_q == '0);
    assign w_full      = (count_q == c_CNT_FULL);
    assign w_top_addr  = c_ADDR_W'(count_q - c_CNT_ONE);
    assign w_push_addr = c_ADDR_W'(count_q);

    always_comb begin
        w_op = OP_IDLE;
        if (bus.clear) begin
            w_op = OP_CLR;
        end else if (bus.push && bus.pop) begin
            w_op = w_empty ? OP_BYP : OP_REPL;
        end else if (bus.push) begin
            w_op = OP_PUSH;
        end else if (bus.pop) begin
            w_op = OP_POP;
        end
    end

    always_comb begin
        count_d      = count_q;
        dout_valid_d = 1'b0;
        overflow_d   = 1'b0;
        underflow_d  = 1'b0;
        byp_sel_d    = byp_sel_q;
        byp_data_d   = byp_data_q;
        w_we         = 1'b0;
        w_re         = 1'b0;
        w_waddr      = w_push_addr;
        case (w_op)
            OP_CLR: begin
                count_d = '0;
            end
            OP_PUSH: begin
                if (w_full) begin
                    overflow_d = 1'b1;
                end else begin
                    w_we    = 1'b1;
                    count_d = count_q + c_CNT_ONE;
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    w_re         = 1'b1;
                    count_d      = count_q - c_CNT_ONE;
                    dout_valid_d = 1'b1;
                    byp_sel_d    = 1'b0;
                end
            end
            OP_REPL: begin
                w_re         = 1'b1;
                w_we         = 1'b1;
                w_waddr      = w_top_addr;
                dout_valid_d = 1'b1;
                byp_sel_d    = 1'b0;
            end
            // Empty push+pop hands din straight to dout without touching memory
            OP_BYP: begin
                byp_sel_d    = 1'b1;
                byp_data_d   = bus.din;
                dout_valid_d = 1'b1;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q      <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            byp_sel_q    <= 1'b0;
            byp_data_q   <= '0;
        end else begin
            count_q      <= count_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            byp_sel_q    <= byp_sel_d;
            byp_data_q   <= byp_data_d;
        end
    end

    lifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rstn  (rstn),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (bus.din),
        .re    (w_re),
        .raddr (w_top_addr),
        .rdata (w_rdata),
        .paddr (w_top_addr),
        .pdata (w_pdata)
    );

    // dout is whichever registered source was loaded last: memory read or bypass
    assign bus.dout         = byp_sel_q ? byp_data_q : w_rdata;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.count        = count_q;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (int'(count_q) >= AFULL_TH);
    assign bus.almost_empty = (int'(count_q) <= AEMPTY_TH);
    assign bus.top          = w_empty ? '0 : w_pdata;

endmodule
`default_nettype wire

// File: tb/tb_lifo_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_lifo_stack
// Description : Vector table, corner sequences and random traffic against a
//               queue-based model of the stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo_stack;
    import lifo_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF_TH = DEPTH - 1;
    localparam int AE_TH = 1;

    logic clk;
    logic rstn;

    lifo_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    lifo_stack #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AF_TH),
        .AEMPTY_TH (AE_TH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       clr;
        logic       psh;
        logic       pp;
        logic [7:0] din;
        int         cnt;
        logic [7:0] dout;
        logic       dv;
        logic       ov;
        logic       un;
        logic [7:0] top;
    } vec_t;

    vec_t vecs[$];

    // Reference model
    logic [7:0] m_stk[$];
    logic [7:0] m_dout;
    logic       m_dv, m_ov, m_un;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void add(input logic c, input logic pu, input logic po, input logic [7:0] d,
                                input int cnt, input logic [7:0] dout, input logic dv,
                                input logic ov, input logic un, input logic [7:0] top);
        vec_t v;
        v.clr = c; v.psh = pu; v.pp = po; v.din = d; v.cnt = cnt;
        v.dout = dout; v.dv = dv; v.ov = ov; v.un = un; v.top = top;
        vecs.push_back(v);
    endfunction

    function automatic void model_update(input logic c, input logic pu, input logic po, input logic [7:0] d);
        logic [2:0] op;
        int n;
        n = m_stk.size();
        m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        if (c)              op = OP_CLR;
        else if (pu && po)  op = (n == 0) ? OP_BYP : OP_REPL;
        else if (pu)        op = OP_PUSH;
        else if (po)        op = OP_POP;
        else                op = OP_IDLE;
        case (op)
            OP_CLR:  m_stk.delete();
            OP_BYP:  begin m_dout = d; m_dv = 1'b1; end
            OP_REPL: begin m_dout = m_stk[n-1]; m_stk[n-1] = d; m_dv = 1'b1; end
            OP_PUSH: if (n >= DEPTH) m_ov = 1'b1; else m_stk.push_back(d);
            OP_POP:  if (n == 0) m_un = 1'b1; else begin m_dout = m_stk.pop_back(); m_dv = 1'b1; end
            default: ;
        endcase
    endfunction

    task automatic step(input logic c, input logic pu, input logic po, input logic [7:0] d);
        bus.clear = c; bus.push = pu; bus.pop = po; bus.din = d;
        @(posedge clk);
        model_update(c, pu, po, d);
        #1;
    endtask

    task automatic check_expect(input string tag, input int cnt, input logic [7:0] dout,
                                input logic dv, input logic ov, input logic un, input logic [7:0] top);
        check({tag, ".count"},        32'(bus.count),        32'(cnt));
        check({tag, ".dout"},         32'(bus.dout),         32'(dout));
        check({tag, ".dout_valid"},   32'(bus.dout_valid),   32'(dv));
        check({tag, ".overflow"},     32'(bus.overflow),     32'(ov));
        check({tag, ".underflow"},    32'(bus.underflow),    32'(un));
        check({tag, ".top"},          32'(bus.top),          32'(top));
        check({tag, ".empty"},        32'(bus.empty),        32'(cnt == 0));
        check({tag, ".full"},         32'(bus.full),         32'(cnt == DEPTH));
        check({tag, ".almost_full"},  32'(bus.almost_full),  32'(cnt >= AF_TH));
        check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= AE_TH));
    endtask

    task automatic check_model(input string tag);
        int n;
        logic [7:0] t;
        n = m_stk.size();
        t = (n == 0) ? 8'h00 : m_stk[n-1];
        check_expect(tag, n, m_dout, m_dv, m_ov, m_un, t);
    endtask

    initial begin
        rstn = 1'b0;
        bus.clear = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.din = '0;
        m_dout = 8'h00; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;

        // Directed vector table
        for (int i = 0; i < 3; i++) add(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 8'(8'h10 + i), i, 8'h00, 0, 0, 0, 8'(8'h10 + i));
        add(0, 1, 0, 8'h99, 8, 8'h00, 0, 1, 0, 8'h18);
        for (int i = 8; i >= 1; i--)
            add(0, 0, 1, 8'h00, i - 1, 8'(8'h10 + i), 1, 0, 0, (i == 1) ? 8'h00 : 8'(8'h10 + i - 1));
        add(0, 0, 1, 8'h00, 0, 8'h11, 0, 0, 1, 8'h00);
        add(0, 1, 0, 8'h31, 1, 8'h11, 0, 0, 0, 8'h31);
        add(0, 1, 0, 8'h32, 2, 8'h11, 0, 0, 0, 8'h32);
        add(0, 1, 0, 8'h33, 3, 8'h11, 0, 0, 0, 8'h33);
        add(0, 1, 1, 8'hAA, 3, 8'h33, 1, 0, 0, 8'hAA);
        for (int i = 4; i <= 8; i++) add(0, 1, 0, 8'(i * 8'h11), i, 8'h33, 0, 0, 0, 8'(i * 8'h11));
        add(0, 1, 1, 8'hBB, 8, 8'h88, 1, 0, 0, 8'hBB);
        add(1, 0, 0, 8'h00, 0, 8'h88, 0, 0, 0, 8'h00);
        add(0, 1, 1, 8'h5C, 0, 8'h5C, 1, 0, 0, 8'h00);
        for (int i = 1; i <= 5; i++) add(0, 1, 0, 8'(i), i, 8'h5C, 0, 0, 0, 8'(i));
        add(1, 1, 0, 8'h77, 0, 8'h5C, 0, 0, 0, 8'h00);

        // Reset state, checked while reset is still held
        #12;
        check_expect("reset", 0, 8'h00, 0, 0, 0, 8'h00);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].psh, vecs[i].pp, vecs[i].din);
            check_expect($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout,
                         vecs[i].dv, vecs[i].ov, vecs[i].un, vecs[i].top);
        end

        // Pop after bypass must return memory data, not the bypassed word
        step(0, 1, 0, 8'hC1);
        step(0, 1, 1, 8'hC2);
        step(0, 0, 1, 8'h00);
        check_model("repl_then_pop");
        step(0, 1, 1, 8'hD7);
        step(0, 1, 0, 8'hE1);
        step(0, 0, 1, 8'h00);
        check_model("byp_then_pop");

        // Asynchronous reset in the middle of a push, before the next edge
        step(0, 1, 0, 8'h42);
        step(0, 1, 0, 8'h43);
        bus.push = 1'b1; bus.din = 8'h44;
        #2;
        rstn = 1'b0;
        bus.push = 1'b0;
        #1;
        check_expect("async_rst", 0, 8'h00, 0, 0, 0, 8'h00);
        m_stk.delete(); m_dout = 8'h00; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        step(0, 0, 0, 8'h00);
        check_model("post_rst_idle");

        // Random traffic with alternating push/pop bias to reach both ends
        for (int blk = 0; blk < 12; blk++) begin
            int bias;
            bias = (blk % 2 == 0) ? 75 : 25;
            for (int k = 0; k < 40; k++) begin
                logic c, pu, po;
                logic [7:0] d;
                c  = ($urandom_range(63) == 0);
                pu = ($urandom_range(99) < bias);
                po = ($urandom_range(99) < (100 - bias));
                d  = 8'($urandom);
                step(c, pu, po, d);
                check_model("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
